tmds_rx_decode: RTL

- Receive-side counterpart of the HDMI/DVI pixel generator.
- Takes three word-aligned 10-bit TMDS symbols per pixel clock from the deserializer. Produces decoded 8-bit red/green/blue, data-enable, hSync/vSync and recovered CounterX/CounterY.
- Also flags protocol errors, so the same debug probe set (CounterX, CounterY, red, green, blue, hSync, vSync) can be observed on the receive path.

---
 rtl/tmds_pkg.sv | 28 ++
 rtl/tmds_decode_chan.sv | 31 +++
 rtl/tmds_rx_decode.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS types, control tokens and data decode function
//
// Purpose: symbol type, the four control tokens ordered by their C[1:0] value,
// and the 10b->8b data decode used by every channel decoder.
package tmds_pkg;

    typedef logic [9:0] tmds_sym_t;

    // Control tokens, indexed by the C[1:0] value they carry.
    localparam tmds_sym_t CTRL_TOKEN_C0 = 10'b1101010100;
    localparam tmds_sym_t CTRL_TOKEN_C1 = 10'b0010101011;
    localparam tmds_sym_t CTRL_TOKEN_C2 = 10'b0101010100;
    localparam tmds_sym_t CTRL_TOKEN_C3 = 10'b1010101011;

    // q[9] undoes the DC-balance inversion; q[8] selects XOR vs XNOR chaining.
    function automatic logic [7:0] tmds_decode_data(input tmds_sym_t q);
        logic [7:0] b;
        logic [7:0] d;
        b    = q[9] ? ~q[7:0] : q[7:0];
        d    = 8'h00;
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_decode_chan.sv
// rtl/tmds_decode_chan.sv - combinational decoder for one TMDS channel
//
// Purpose: classify one symbol as control or data and decode it.
// Ports:
//   sym_i      10-bit TMDS symbol
//   is_ctrl_o  symbol is one of the four control tokens
//   ctrl_o     C[1:0] of the control token (0 for data symbols)
//   data_o     decoded 8-bit data (meaningful only for data symbols)
module tmds_decode_chan
    import tmds_pkg::*;
(
    input  tmds_sym_t   sym_i,
    output logic        is_ctrl_o,
    output logic [1:0]  ctrl_o,
    output logic [7:0]  data_o
);

    always_comb begin
        is_ctrl_o = 1'b1;
        ctrl_o    = 2'd0;
        case (sym_i)
            CTRL_TOKEN_C0: ctrl_o = 2'd0;
            CTRL_TOKEN_C1: ctrl_o = 2'd1;
            CTRL_TOKEN_C2: ctrl_o = 2'd2;
            CTRL_TOKEN_C3: ctrl_o = 2'd3;
            default:       is_ctrl_o = 1'b0;
        endcase
        data_o = tmds_decode_data(sym_i);
    end

endmodule

// File: rtl/tmds_rx_decode.sv
// rtl/tmds_rx_decode.sv - TMDS receive decoder with timing recovery and error flags
//
// Purpose: two-stage pipeline (raw symbols, then decoded outputs) that advances
// only on sym_valid; recovers de/hSync/vSync, CounterX/CounterY and flags
// line-length, frame-height and channel-disagreement errors.
// Ports:
//   clk, rst                  pixel clock, synchronous active-high reset
//   sym_valid                 symbol strobe; low holds the whole pipeline
//   sym_blue/green/red        10-bit TMDS symbols for channels 0/1/2
//   red/green/blue, de        decoded pixel and active-video flag
//   hSync, vSync              blue-channel C0/C1
//   CounterX, CounterY        active pixel / active line index
//   locked, frame_start       vSync edge seen since reset / pulse on that edge
//   line_err, frame_err       pixel / line count mismatch pulses
//   de_mismatch               channels disagree on control vs data
module tmds_rx_decode
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sym_valid,
    input  logic [9:0]    sym_blue,
    input  logic [9:0]    sym_green,
    input  logic [9:0]    sym_red,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic          de,
    output logic          hSync,
    output logic          vSync,
    output logic [CW-1:0] CounterX,
    output logic [CW-1:0] CounterY,
    output logic          locked,
    output logic          frame_start,
    output logic          line_err,
    output logic          frame_err,
    output logic          de_mismatch
);

    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW:0]   LMAX = '1;
    localparam logic [CW:0]   H_EXP = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   V_EXP = (CW+1)'(V_ACTIVE);

    // Stage 1: raw symbols; s1_full_q keeps post-reset zeros from being decoded.
    tmds_sym_t sb_q, sg_q, sr_q;
    logic      s1_full_q;

    logic       b_is_ctrl, g_is_ctrl, r_is_ctrl;
    logic [1:0] b_ctrl, g_ctrl, r_ctrl;
    logic [7:0] b_data, g_data, r_data;

    tmds_decode_chan u_dec_b (.sym_i(sb_q), .is_ctrl_o(b_is_ctrl), .ctrl_o(b_ctrl), .data_o(b_data));
    tmds_decode_chan u_dec_g (.sym_i(sg_q), .is_ctrl_o(g_is_ctrl), .ctrl_o(g_ctrl), .data_o(g_data));
    tmds_decode_chan u_dec_r (.sym_i(sr_q), .is_ctrl_o(r_is_ctrl), .ctrl_o(r_ctrl), .data_o(r_data));

    // Stage 2 state
    logic [7:0]    red_q, green_q, blue_q, red_d, green_d, blue_d;
    logic          de_q, hs_q, vs_q, de_d, hs_d, vs_d;
    logic [CW-1:0] cx_q, cy_q, cx_d, cy_d;
    logic          locked_q, fs_q, lerr_q, ferr_q, mis_q;
    logic          locked_d, fs_d, lerr_d, ferr_d, mis_d;
    logic          first_q, first_d;   // next de rise is line 0 of a new frame
    logic [CW:0]   lines_q, lines_d;   // active lines since last vSync edge
    logic          vs_rise, de_rise, de_fall;
    logic [CW:0]   pix_cnt;

    always_comb begin
        de_d    = ~b_is_ctrl;
        hs_d    = b_is_ctrl ? b_ctrl[0] : hs_q;
        vs_d    = b_is_ctrl ? b_ctrl[1] : vs_q;
        red_d   = de_d ? r_data : red_q;
        green_d = de_d ? g_data : green_q;
        blue_d  = de_d ? b_data : blue_q;
        mis_d   = (g_is_ctrl != b_is_ctrl) || (r_is_ctrl != b_is_ctrl);

        vs_rise = vs_d & ~vs_q;
        de_rise = de_d & ~de_q;
        de_fall = de_q & ~de_d;
        // cx_q holds the index of the last active pixel, so the line length is one more.
        pix_cnt = {1'b0, cx_q} + 1'b1;

        cx_d = cx_q;
        if (de_rise) begin
            cx_d = '0;
        end else if (de_d && cx_q != CMAX) begin
            cx_d = cx_q + 1'b1;
        end

        // vSync edges only happen on control symbols and de rises only on data
        // symbols, so the two updates below never collide.
        cy_d    = cy_q;
        first_d = first_q;
        lines_d = lines_q;
        if (vs_rise) begin
            first_d = 1'b1;
            lines_d = '0;
        end
        if (de_rise) begin
            if (first_q) begin
                cy_d    = '0;
                first_d = 1'b0;
            end else if (cy_q != CMAX) begin
                cy_d = cy_q + 1'b1;
            end
            if (lines_q != LMAX) begin
                lines_d = lines_q + 1'b1;
            end
        end

        fs_d     = vs_rise;
        locked_d = locked_q | vs_rise;
        ferr_d   = vs_rise & locked_q & (lines_q != V_EXP);
        lerr_d   = de_fall & (pix_cnt != H_EXP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0; sg_q <= '0; sr_q <= '0; s1_full_q <= 1'b0;
            red_q <= '0; green_q <= '0; blue_q <= '0;
            de_q <= 1'b0; hs_q <= 1'b0; vs_q <= 1'b0;
            cx_q <= '0; cy_q <= '0; first_q <= 1'b0; lines_q <= '0;
            locked_q <= 1'b0; fs_q <= 1'b0; lerr_q <= 1'b0; ferr_q <= 1'b0; mis_q <= 1'b0;
        end else if (sym_valid) begin
            sb_q      <= sym_blue;
            sg_q      <= sym_green;
            sr_q      <= sym_red;
            s1_full_q <= 1'b1;
            if (s1_full_q) begin
                red_q <= red_d; green_q <= green_d; blue_q <= blue_d;
                de_q <= de_d; hs_q <= hs_d; vs_q <= vs_d;
                cx_q <= cx_d; cy_q <= cy_d; first_q <= first_d; lines_q <= lines_d;
                locked_q <= locked_d; fs_q <= fs_d; lerr_q <= lerr_d;
                ferr_q <= ferr_d; mis_q <= mis_d;
            end else begin
                fs_q <= 1'b0; lerr_q <= 1'b0; ferr_q <= 1'b0; mis_q <= 1'b0;
            end
        end else begin
            fs_q <= 1'b0; lerr_q <= 1'b0; ferr_q <= 1'b0; mis_q <= 1'b0;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign de          = de_q;
    assign hSync       = hs_q;
    assign vSync       = vs_q;
    assign CounterX    = cx_q;
    assign CounterY    = cy_q;
    assign locked      = locked_q;
    assign frame_start = fs_q;
    assign line_err    = lerr_q;
    assign frame_err   = ferr_q;
    assign de_mismatch = mis_q;

endmodule
